uart_cfg_ctrl: RTL and testbench



---
 rtl/uart_cfg_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_uart_cfg_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_ctrl.sv
// uart_cfg_ctrl
// Collects SYNC/ADDR/DATA(/CHK) frames from a UART receiver and writes
// validated bytes into a bank of 8-bit configuration registers.
// Optional feature macro: UART_CFG_CHECKSUM_EN
//   defined   -> 4-byte frames with CHK = 0xA5 ^ ADDR ^ DATA
//   undefined -> 3-byte frames; commit follows DATA directly
module uart_cfg_ctrl #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int TIMEOUT_CLKS = 20*CLKS_PER_BIT,
   parameter int NUM_REGS     = 4,
   localparam int AW          = $clog2(NUM_REGS)
) (
   input  logic                  i_Clock,
   input  logic                  i_Rst_n,
   input  logic                  i_Enable,
   input  logic                  i_Rx_DV,
   input  logic [7:0]            i_Rx_Byte,
   output logic                  o_Rx_Enable,
   output logic                  o_Cfg_Wr,
   output logic [AW-1:0]         o_Cfg_Addr,
   output logic [7:0]            o_Cfg_Data,
   output logic [8*NUM_REGS-1:0] o_Cfg_Regs,
   output logic                  o_Frame_Err,
   output logic                  o_Busy
);

   localparam int         CW   = $clog2(TIMEOUT_CLKS+1);
   localparam logic [7:0] SYNC = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      GET_ADDR,
      GET_DATA,
`ifdef UART_CFG_CHECKSUM_EN
      GET_CHK,
`endif
      COMMIT
   } state_t;

   state_t          r_State;
   state_t          w_NextState;
   logic [7:0]      r_Addr;
   logic [7:0]      r_Data;
   logic [CW-1:0]   r_Cnt;
   logic [AW-1:0]   r_CfgAddr;
   logic [7:0]      r_CfgData;
   logic [7:0]      r_Bank [NUM_REGS];
   logic            r_Err;
   logic            r_RxEn;

   logic            w_InGet;
   logic            w_Timeout;
   logic            w_AddrOk;
   logic            w_ErrNext;
   logic            w_Commit;
   logic [7:0]      w_CommitData;
   logic            w_LatchAddr;
   logic            w_LatchData;
   logic [8*NUM_REGS-1:0] w_Regs;

   assign w_InGet   = (r_State != IDLE) && (r_State != COMMIT);
   assign w_Timeout = (r_Cnt == CW'(TIMEOUT_CLKS-1));
   assign w_AddrOk  = ({1'b0, r_Addr} < 9'(NUM_REGS));

   // Next-state decode: enable beats byte strobes, which beat the timeout
   always_comb begin
      w_NextState  = r_State;
      w_ErrNext    = 1'b0;
      w_Commit     = 1'b0;
      w_CommitData = r_Data;
      w_LatchAddr  = 1'b0;
      w_LatchData  = 1'b0;
      if (!i_Enable) begin
         w_NextState = IDLE;
      end else if (w_InGet && !i_Rx_DV && w_Timeout) begin
         w_NextState = IDLE;
         w_ErrNext   = 1'b1;
      end else begin
         case (r_State)
            IDLE: begin
               if (i_Rx_DV && (i_Rx_Byte == SYNC)) w_NextState = GET_ADDR;
            end
            GET_ADDR: begin
               if (i_Rx_DV) begin
                  w_LatchAddr = 1'b1;
                  w_NextState = GET_DATA;
               end
            end
            GET_DATA: begin
               if (i_Rx_DV) begin
`ifdef UART_CFG_CHECKSUM_EN
                  w_LatchData = 1'b1;
                  w_NextState = GET_CHK;
`else
                  if (w_AddrOk) begin
                     w_Commit     = 1'b1;
                     w_CommitData = i_Rx_Byte;
                     w_NextState  = COMMIT;
                  end else begin
                     w_ErrNext   = 1'b1;
                     w_NextState = IDLE;
                  end
`endif
               end
            end
`ifdef UART_CFG_CHECKSUM_EN
            GET_CHK: begin
               if (i_Rx_DV) begin
                  if ((i_Rx_Byte == (SYNC ^ r_Addr ^ r_Data)) && w_AddrOk) begin
                     w_Commit    = 1'b1;
                     w_NextState = COMMIT;
                  end else begin
                     w_ErrNext   = 1'b1;
                     w_NextState = IDLE;
                  end
               end
            end
`endif
            COMMIT:  w_NextState = IDLE;
            default: w_NextState = IDLE;
         endcase
      end
   end

   // State, error pulse, receiver enable and frame field capture
   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         r_State   <= IDLE;
         r_Err     <= 1'b0;
         r_RxEn    <= 1'b0;
         r_Addr    <= '0;
         r_Data    <= '0;
         r_CfgAddr <= '0;
         r_CfgData <= '0;
      end else begin
         r_State <= w_NextState;
         r_Err   <= w_ErrNext;
         r_RxEn  <= i_Enable;
         if (w_LatchAddr) r_Addr <= i_Rx_Byte;
         if (w_LatchData) r_Data <= i_Rx_Byte;
         if (w_Commit) begin
            r_CfgAddr <= r_Addr[AW-1:0];
            r_CfgData <= w_CommitData;
         end
      end
   end

   // Inter-byte timeout counter; cleared outside frames and on each byte, saturating
   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         r_Cnt <= '0;
      end else if (!i_Enable || !w_InGet || i_Rx_DV) begin
         r_Cnt <= '0;
      end else if (r_Cnt != {CW{1'b1}}) begin
         r_Cnt <= r_Cnt + 1'b1;
      end
   end

   // Configuration register bank, written during the COMMIT cycle
   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         for (int k = 0; k < NUM_REGS; k++) r_Bank[k] <= '0;
      end else if (r_State == COMMIT) begin
         r_Bank[r_CfgAddr] <= r_CfgData;
      end
   end

   // Flatten the bank onto the packed output bus
   always_comb begin
      w_Regs = '0;
      for (int k = 0; k < NUM_REGS; k++) w_Regs[8*k +: 8] = r_Bank[k];
   end

   assign o_Rx_Enable = r_RxEn;
   assign o_Cfg_Wr    = (r_State == COMMIT);
   assign o_Cfg_Addr  = r_CfgAddr;
   assign o_Cfg_Data  = r_CfgData;
   assign o_Cfg_Regs  = w_Regs;
   assign o_Frame_Err = r_Err;
   assign o_Busy      = (r_State != IDLE);

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Testbench for uart_cfg_ctrl: directed frames from the test plan followed by
// randomized frames, all checked every cycle against a byte-count frame model.
module tb_uart_cfg_ctrl;

   localparam int T  = 40;
   localparam int NR = 4;
`ifdef UART_CFG_CHECKSUM_EN
   localparam int FB = 4;
`else
   localparam int FB = 3;
`endif

   logic        clock;
   logic        rstN;
   logic        enable;
   logic        rxDv;
   logic [7:0]  rxByte;
   logic        rxEnable;
   logic        cfgWr;
   logic [1:0]  cfgAddr;
   logic [7:0]  cfgData;
   logic [31:0] cfgRegs;
   logic        frameErr;
   logic        busy;

   int compared   = 0;
   int mismatched = 0;
   int errPulses  = 0;
   int wrPulses   = 0;

   uart_cfg_ctrl #(
      .CLKS_PER_BIT (2),
      .TIMEOUT_CLKS (T),
      .NUM_REGS     (NR)
   ) dut (
      .i_Clock     (clock),
      .i_Rst_n     (rstN),
      .i_Enable    (enable),
      .i_Rx_DV     (rxDv),
      .i_Rx_Byte   (rxByte),
      .o_Rx_Enable (rxEnable),
      .o_Cfg_Wr    (cfgWr),
      .o_Cfg_Addr  (cfgAddr),
      .o_Cfg_Data  (cfgData),
      .o_Cfg_Regs  (cfgRegs),
      .o_Frame_Err (frameErr),
      .o_Busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: counts frame bytes collected and idle clocks since the last byte
   bit          modelValid = 1'b0;
   int          mNBytes;
   int          mIdle;
   bit          mPending;
   logic [7:0]  mFrm [4];
   logic [7:0]  mRegs [NR];
   logic        mRxEn, mWr, mErr, mBusy;
   logic [7:0]  mAddr, mData;
   logic [31:0] mRegsPacked;

   function automatic bit frameOk();
      bit ok;
      ok = (mFrm[1] < 8'(NR));
      if (FB == 4) ok = ok && (mFrm[3] == (8'hA5 ^ mFrm[1] ^ mFrm[2]));
      return ok;
   endfunction

   task automatic modelStep();
      if (!rstN) begin
         mRxEn = 0; mWr = 0; mErr = 0; mBusy = 0;
         mAddr = 0; mData = 0;
         mNBytes = 0; mIdle = 0; mPending = 0;
         for (int k = 0; k < NR; k++) mRegs[k] = 8'h00;
         modelValid = 1'b1;
      end else begin
         mRxEn = enable;
         mErr  = 0;
         if (mPending) begin
            mRegs[mAddr[1:0]] = mData;
            mPending = 0;
            mNBytes  = 0;
         end else if (!enable) begin
            mNBytes = 0;
            mIdle   = 0;
         end else if (mNBytes == 0) begin
            if (rxDv && rxByte == 8'hA5) begin
               mFrm[0] = 8'hA5;
               mNBytes = 1;
               mIdle   = 0;
            end
         end else if (rxDv) begin
            mFrm[mNBytes] = rxByte;
            mNBytes++;
            mIdle = 0;
            if (mNBytes == FB) begin
               mNBytes = 0;
               if (frameOk()) begin
                  mPending = 1;
                  mAddr    = mFrm[1];
                  mData    = mFrm[2];
               end else begin
                  mErr = 1;
               end
            end
         end else if (mIdle == T-1) begin
            mErr    = 1;
            mNBytes = 0;
         end else begin
            mIdle++;
         end
         mWr   = mPending;
         mBusy = (mNBytes != 0) || mPending;
      end
      for (int k = 0; k < NR; k++) mRegsPacked[8*k +: 8] = mRegs[k];
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model advances on every rising edge using the inputs that edge sampled
   initial forever begin
      @(posedge clock);
      modelStep();
   end

   // Per-cycle comparison of every DUT output, plus pulse counting
   initial forever begin
      @(negedge clock);
      if (modelValid) begin
         checkOutput("rx_enable", 32'(rxEnable), 32'(mRxEn));
         checkOutput("cfg_wr",    32'(cfgWr),    32'(mWr));
         checkOutput("cfg_addr",  32'(cfgAddr),  32'(mAddr[1:0]));
         checkOutput("cfg_data",  32'(cfgData),  32'(mData));
         checkOutput("cfg_regs",  cfgRegs,       mRegsPacked);
         checkOutput("frame_err", 32'(frameErr), 32'(mErr));
         checkOutput("busy",      32'(busy),     32'(mBusy));
         if (frameErr === 1'b1) errPulses++;
         if (cfgWr === 1'b1)    wrPulses++;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One byte strobe, then 'gap' idle cycles
   task automatic applyStimulus(input logic [7:0] b, input int gap);
      rxDv   = 1'b1;
      rxByte = b;
      tick();
      rxDv   = 1'b0;
      rxByte = $urandom_range(0, 255);
      repeat (gap) tick();
   endtask

   task automatic sendFrame(input logic [7:0] addr, input logic [7:0] data,
                            input logic [7:0] chk, input int innerGap, input int endGap);
      applyStimulus(8'hA5, innerGap);
      applyStimulus(addr, innerGap);
`ifdef UART_CFG_CHECKSUM_EN
      applyStimulus(data, innerGap);
      applyStimulus(chk, endGap);
`else
      applyStimulus(data, endGap);
      if (chk == 8'h00) begin end
`endif
   endtask

   initial begin
      int waited;
      int kind;
      logic [7:0] a, d;

      rstN = 1'b0; enable = 1'b0; rxDv = 1'b0; rxByte = 8'h00;
      repeat (3) tick();
      checkOutput("reset_regs",   cfgRegs,          32'h0);
      checkOutput("reset_busy",   32'(busy),        32'h0);
      checkOutput("reset_rx_en",  32'(rxEnable),    32'h0);
      rstN = 1'b1; enable = 1'b1;
      repeat (2) tick();
      checkOutput("rx_en_follow", 32'(rxEnable),    32'h1);

      // Valid write to register 2
      sendFrame(8'h02, 8'h3C, 8'h9B, 0, 0);
      repeat (3) tick();
      checkOutput("t1_regs",  cfgRegs,          32'h003C_0000);
      checkOutput("t1_wr",    32'(wrPulses),    32'd1);
      checkOutput("t1_err",   32'(errPulses),   32'd0);

      // Corrupted frame: bad checksum, or out-of-range address without checksum
`ifdef UART_CFG_CHECKSUM_EN
      sendFrame(8'h01, 8'h55, 8'h00, 0, 3);
`else
      sendFrame(8'h05, 8'h55, 8'h00, 0, 3);
`endif
      checkOutput("t2_err",   32'(errPulses),   32'd1);
      checkOutput("t2_regs",  cfgRegs,          32'h003C_0000);

      // Address beyond the bank
      sendFrame(8'h07, 8'h11, 8'hB3, 0, 3);
      checkOutput("t3_err",   32'(errPulses),   32'd2);
      checkOutput("t3_wr",    32'(wrPulses),    32'd1);

      // Inter-byte timeout, then recovery with a valid frame
      applyStimulus(8'hA5, 0);
      applyStimulus(8'h01, 0);
      waited = 0;
      while (frameErr !== 1'b1 && waited < T + 10) begin
         tick();
         waited++;
      end
      checkOutput("timeout_latency", 32'(waited), 32'(T));
      checkOutput("timeout_busy",    32'(busy),   32'h0);
      tick();
      sendFrame(8'h01, 8'hAA, 8'h0E, 1, 3);
      checkOutput("t4_regs",  cfgRegs,          32'h003C_AA00);

      // Noise, partial frame aborted by disabling
      applyStimulus(8'h00, 1);
      applyStimulus(8'hFF, 1);
      applyStimulus(8'hA5, 0);
      applyStimulus(8'h03, 1);
      enable = 1'b0;
      tick();
      checkOutput("dis_rx_en", 32'(rxEnable),   32'h0);
      checkOutput("dis_busy",  32'(busy),       32'h0);
      checkOutput("dis_err",   32'(errPulses),  32'd3);
      enable = 1'b1;
      tick();
      sendFrame(8'h03, 8'h5A, 8'hFC, 0, 3);
      checkOutput("t5_regs",  cfgRegs,          32'h5A3C_AA00);

      // Reset mid-frame clears everything
      sendFrame(8'h00, 8'h77, 8'hD2, 0, 3);
      checkOutput("t6_regs",  cfgRegs,          32'h5A3C_AA77);
      applyStimulus(8'hA5, 0);
      applyStimulus(8'h02, 1);
      rstN = 1'b0;
      tick();
      checkOutput("rst_regs", cfgRegs,          32'h0);
      checkOutput("rst_busy", 32'(busy),        32'h0);
      checkOutput("rst_addr", 32'(cfgAddr),     32'h0);
      checkOutput("rst_data", 32'(cfgData),     32'h0);
      rstN = 1'b1;
      tick();

      // Randomized traffic
      for (int it = 0; it < 120; it++) begin
         kind = $urandom_range(0, 5);
         a = 8'($urandom_range(0, NR-1));
         d = 8'($urandom_range(0, 255));
         case (kind)
            0, 1: sendFrame(a, d, 8'hA5 ^ a ^ d, $urandom_range(0, 3), $urandom_range(0, 3));
            2:    sendFrame(a, d, 8'hA5 ^ a ^ d ^ 8'h10, $urandom_range(0, 3), $urandom_range(0, 3));
            3:    sendFrame(8'($urandom_range(NR, 255)), d, 8'hA5 ^ 8'h09 ^ d, $urandom_range(0, 3), $urandom_range(0, 3));
            4:    applyStimulus(8'($urandom_range(0, 255)), $urandom_range(0, 3));
            default: begin
               applyStimulus(8'hA5, $urandom_range(0, 3));
               applyStimulus(a, $urandom_range(1, 3));
               if ($urandom_range(0, 1) == 1) begin
                  repeat (T + $urandom_range(0, 4)) tick();
               end else begin
                  enable = 1'b0;
                  repeat ($urandom_range(1, 3)) tick();
                  enable = 1'b1;
                  tick();
               end
            end
         endcase
      end
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
